// File: rtl/paddle_pkg.sv
// Shared types, constants and saturating step helper for the paddle potentiometer emulation.
package paddle_pkg;

  typedef enum logic [1:0] {
    MODE_DIGITAL  = 2'd0,
    MODE_ANALOG_Y = 2'd1,
    MODE_ANALOG_X = 2'd2,
    MODE_RSVD     = 2'd3
  } ctrl_mode_t;

  localparam logic [7:0] POS_MIN = 8'd0;
  localparam logic [7:0] POS_MAX = 8'd255;
  localparam int         CAP_W   = 9;

  // dir=1 moves down (towards POS_MAX), dir=0 moves up (towards POS_MIN); 9-bit math catches carry/borrow.
  function automatic logic [7:0] sat_step(input logic [7:0] pos, input logic [7:0] step, input logic dir);
    logic [8:0] t;
    if (dir) begin
      t = {1'b0, pos} + {1'b0, step};
      sat_step = t[8] ? POS_MAX : t[7:0];
    end else begin
      t = {1'b0, pos} - {1'b0, step};
      sat_step = t[8] ? POS_MIN : t[7:0];
    end
  endfunction

endpackage

// File: rtl/paddle_channel.sv
// One player's position, line countdown and (with PADDLE_ACCEL_EN) hold-to-accelerate counter.
module paddle_channel
  import paddle_pkg::*;
#(
  parameter int CENTRE    = 128,
  parameter int STEP_SLOW = 5,
  parameter int STEP_FAST = 8
`ifdef PADDLE_ACCEL_EN
  ,
  parameter int ACCEL_FRAMES = 3
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame,
  input  logic        line,
  input  logic [1:0]  mode,
  input  logic        speed,
  input  logic        up,
  input  logic        down,
  input  logic [15:0] analog,
  output logic [7:0]  pos,
  output logic        cap_zero
);

  logic [CAP_W-1:0] cap;
  logic [CAP_W-1:0] cap_nxt;
  logic [7:0]       pos_nxt;
  logic [7:0]       base_step;
  logic [7:0]       step;
  logic [7:0]       v;
  logic             is_analog;
  logic             single_dir;

  assign single_dir = up ^ down;
  assign cap_zero   = (cap == {CAP_W{1'b0}});

`ifdef PADDLE_ACCEL_EN
  logic [3:0] hold;
  logic [3:0] hold_nxt;
  logic [3:0] eff_hold;
  logic [7:0] accel_step;
  logic       last_dir;
  logic       last_dir_nxt;

  // Step grows by one every ACCEL_FRAMES held frames, capped at the speed-selected step.
  always_comb begin
    base_step    = speed ? 8'(STEP_FAST) : 8'(STEP_SLOW);
    eff_hold     = (down == last_dir) ? hold : 4'd0;
    accel_step   = 8'd1 + (8'(eff_hold) / 8'(ACCEL_FRAMES));
    step         = (accel_step < base_step) ? accel_step : base_step;
    hold_nxt     = hold;
    last_dir_nxt = last_dir;
    if (frame) begin
      if (!is_analog && single_dir) begin
        hold_nxt     = (eff_hold == 4'd15) ? 4'd15 : eff_hold + 4'd1;
        last_dir_nxt = down;
      end else begin
        hold_nxt = 4'd0;
      end
    end else begin
      hold_nxt = hold;
    end
  end

  // Hold counter and the direction it was counting for.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold     <= 4'd0;
      last_dir <= 1'b0;
    end else begin
      hold     <= hold_nxt;
      last_dir <= last_dir_nxt;
    end
  end
`else
  // Fixed step selected by speed.
  always_comb begin
    base_step = speed ? 8'(STEP_FAST) : 8'(STEP_SLOW);
    step      = base_step;
  end
`endif

  // Frame loads the countdown (digital: previous pos, analog: new pos); lines count it down.
  always_comb begin
    pos_nxt   = pos;
    cap_nxt   = cap;
    v         = analog[7:0];
    is_analog = 1'b0;
    case (ctrl_mode_t'(mode))
      MODE_ANALOG_Y: begin
        v         = analog[15:8];
        is_analog = 1'b1;
      end
      MODE_ANALOG_X: begin
        v         = analog[7:0];
        is_analog = 1'b1;
      end
      default: begin
        v         = analog[7:0];
        is_analog = 1'b0;
      end
    endcase
    if (frame) begin
      if (is_analog) begin
        pos_nxt = {~v[7], v[6:0]};
        cap_nxt = {1'b0, ~v[7], v[6:0]};
      end else begin
        cap_nxt = {1'b0, pos};
        if (single_dir) begin
          pos_nxt = sat_step(pos, step, down);
        end else begin
          pos_nxt = pos;
        end
      end
    end else if (line) begin
      if (cap_zero) begin
        cap_nxt = cap;
      end else begin
        cap_nxt = cap - CAP_W'(1);
      end
    end else begin
      cap_nxt = cap;
    end
  end

  // Position and countdown state.
  always_ff @(posedge clk) begin
    if (reset) begin
      pos <= 8'(CENTRE);
      cap <= {CAP_W{1'b0}};
    end else begin
      pos <= pos_nxt;
      cap <= cap_nxt;
    end
  end

endmodule

// File: rtl/paddle_pot_emu.sv
// Paddle potentiometer/RC emulation feeding lp_in/rp_in of the AY-3-8500 core.
// Optional hold acceleration is built when PADDLE_ACCEL_EN is defined.
module paddle_pot_emu
  import paddle_pkg::*;
#(
  parameter int CENTRE    = 128,
  parameter int STEP_SLOW = 5,
  parameter int STEP_FAST = 8
`ifdef PADDLE_ACCEL_EN
  ,
  parameter int ACCEL_FRAMES = 3
`endif
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        hs,
  input  logic        vs,
  input  logic [1:0]  mode,
  input  logic        speed,
  input  logic        p1_up,
  input  logic        p1_down,
  input  logic        p2_up,
  input  logic        p2_down,
  input  logic [15:0] analog0,
  input  logic [15:0] analog1,
  output logic        lp_in,
  output logic        rp_in,
  output logic [7:0]  p1_pos,
  output logic [7:0]  p2_pos
);

  logic hs_old;
  logic vs_old;
  logic rise_vs;
  logic rise_hs;
  logic line;

  assign rise_vs = vs & ~vs_old;
  assign rise_hs = hs & ~hs_old;
  // A frame edge swallows a coincident line edge.
  assign line    = rise_hs & ~rise_vs;

  // Sync level history for edge detection.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      hs_old <= 1'b0;
      vs_old <= 1'b0;
    end else begin
      hs_old <= hs;
      vs_old <= vs;
    end
  end

  paddle_channel #(
    .CENTRE      (CENTRE),
    .STEP_SLOW   (STEP_SLOW),
    .STEP_FAST   (STEP_FAST)
`ifdef PADDLE_ACCEL_EN
    ,
    .ACCEL_FRAMES(ACCEL_FRAMES)
`endif
  ) u_left (
    .clk     (clk_sys),
    .reset   (reset),
    .frame   (rise_vs),
    .line    (line),
    .mode    (mode),
    .speed   (speed),
    .up      (p1_up),
    .down    (p1_down),
    .analog  (analog0),
    .pos     (p1_pos),
    .cap_zero(lp_in)
  );

  paddle_channel #(
    .CENTRE      (CENTRE),
    .STEP_SLOW   (STEP_SLOW),
    .STEP_FAST   (STEP_FAST)
`ifdef PADDLE_ACCEL_EN
    ,
    .ACCEL_FRAMES(ACCEL_FRAMES)
`endif
  ) u_right (
    .clk     (clk_sys),
    .reset   (reset),
    .frame   (rise_vs),
    .line    (line),
    .mode    (mode),
    .speed   (speed),
    .up      (p2_up),
    .down    (p2_down),
    .analog  (analog1),
    .pos     (p2_pos),
    .cap_zero(rp_in)
  );

endmodule

// File: tb/tb_paddle_pot_emu.sv
// Directed self-checking bench for paddle_pot_emu (default build, no acceleration).
module tb_paddle_pot_emu;

  logic        clk_sys = 1'b0;
  logic        reset   = 1'b1;
  logic        hs      = 1'b0;
  logic        vs      = 1'b0;
  logic [1:0]  mode    = 2'd0;
  logic        speed   = 1'b0;
  logic        p1_up   = 1'b0;
  logic        p1_down = 1'b0;
  logic        p2_up   = 1'b0;
  logic        p2_down = 1'b0;
  logic [15:0] analog0 = 16'h0000;
  logic [15:0] analog1 = 16'h0000;
  logic        lp_in;
  logic        rp_in;
  logic [7:0]  p1_pos;
  logic [7:0]  p2_pos;

  int errors = 0;
  int checks = 0;

  always #5 clk_sys = ~clk_sys;

  paddle_pot_emu dut (
    .clk_sys(clk_sys), .reset(reset), .hs(hs), .vs(vs), .mode(mode), .speed(speed),
    .p1_up(p1_up), .p1_down(p1_down), .p2_up(p2_up), .p2_down(p2_down),
    .analog0(analog0), .analog1(analog1),
    .lp_in(lp_in), .rp_in(rp_in), .p1_pos(p1_pos), .p2_pos(p2_pos)
  );

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic frame();
    vs = 1'b1; tick();
    vs = 1'b0; tick();
  endtask

  task automatic line();
    hs = 1'b1; tick();
    hs = 1'b0; tick();
  endtask

  // Lines until the chosen paddle level goes high; 300 means it never did.
  task automatic count_lines(input bit right, output int n);
    n = 0;
    while (((right ? rp_in : lp_in) == 1'b0) && (n < 300)) begin
      line();
      n++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; tick(); tick();
    reset = 1'b0; tick(); tick();
    checks++; if (lp_in !== 1'b1) begin errors++; $display("FAIL reset_lp: got %0b want 1", lp_in); end
    checks++; if (rp_in !== 1'b1) begin errors++; $display("FAIL reset_rp: got %0b want 1", rp_in); end
    checks++; if (p1_pos !== 8'd128) begin errors++; $display("FAIL reset_p1: got %0d want 128", p1_pos); end
    checks++; if (p2_pos !== 8'd128) begin errors++; $display("FAIL reset_p2: got %0d want 128", p2_pos); end
  endtask

  task automatic test_digital_down();
    int n;
    mode = 2'd0; speed = 1'b0; p1_down = 1'b1;
    frame();
    checks++; if (p1_pos !== 8'd133) begin errors++; $display("FAIL down_f1: got %0d want 133", p1_pos); end
    checks++; if (lp_in !== 1'b0) begin errors++; $display("FAIL down_f1_lp: got %0b want 0", lp_in); end
    checks++; if (p2_pos !== 8'd128) begin errors++; $display("FAIL down_p2_idle: got %0d want 128", p2_pos); end
    frame();
    checks++; if (p1_pos !== 8'd138) begin errors++; $display("FAIL down_f2: got %0d want 138", p1_pos); end
    count_lines(1'b0, n);
    checks++; if (n !== 133) begin errors++; $display("FAIL down_lines: got %0d want 133", n); end
    frame();
    checks++; if (p1_pos !== 8'd143) begin errors++; $display("FAIL down_f3: got %0d want 143", p1_pos); end
    p1_down = 1'b0;
  endtask

  task automatic test_both_held();
    int n;
    p1_up = 1'b1; p1_down = 1'b1;
    for (int f = 0; f < 5; f++) begin
      frame();
      checks++; if (p1_pos !== 8'd143) begin errors++; $display("FAIL both_held f%0d: got %0d want 143", f, p1_pos); end
    end
    p1_up = 1'b0; p1_down = 1'b0;
    vs = 1'b1; hs = 1'b1; tick();
    vs = 1'b0; hs = 1'b0; tick();
    count_lines(1'b0, n);
    checks++; if (n !== 143) begin errors++; $display("FAIL same_edge_lines: got %0d want 143", n); end
  endtask

  task automatic test_saturate();
    // Preload pos1=3 (0x83 -> 3) and pos2=250 (0x7A -> 250) via analog Y.
    mode = 2'd1; analog0 = 16'h8300; analog1 = 16'h7A00;
    frame();
    checks++; if (p1_pos !== 8'd3) begin errors++; $display("FAIL preload_p1: got %0d want 3", p1_pos); end
    checks++; if (p2_pos !== 8'd250) begin errors++; $display("FAIL preload_p2: got %0d want 250", p2_pos); end
    mode = 2'd0; speed = 1'b1; p1_up = 1'b1; p2_down = 1'b1;
    frame();
    checks++; if (p1_pos !== 8'd0) begin errors++; $display("FAIL sat_low: got %0d want 0", p1_pos); end
    checks++; if (p2_pos !== 8'd255) begin errors++; $display("FAIL sat_high: got %0d want 255", p2_pos); end
    frame();
    checks++; if (p1_pos !== 8'd0) begin errors++; $display("FAIL sat_low_hold: got %0d want 0", p1_pos); end
    checks++; if (lp_in !== 1'b1) begin errors++; $display("FAIL sat_low_lp: got %0b want 1", lp_in); end
    checks++; if (p2_pos !== 8'd255) begin errors++; $display("FAIL sat_high_hold: got %0d want 255", p2_pos); end
    checks++; if (rp_in !== 1'b0) begin errors++; $display("FAIL sat_high_rp: got %0b want 0", rp_in); end
    p1_up = 1'b0; p2_down = 1'b0; speed = 1'b0;
  endtask

  task automatic test_analog();
    int n;
    mode = 2'd1; analog0 = 16'h8000;
    frame();
    checks++; if (p1_pos !== 8'd0) begin errors++; $display("FAIL ana_min: got %0d want 0", p1_pos); end
    checks++; if (lp_in !== 1'b1) begin errors++; $display("FAIL ana_min_lp: got %0b want 1", lp_in); end
    analog0 = 16'h7F00;
    frame();
    checks++; if (p1_pos !== 8'd255) begin errors++; $display("FAIL ana_max: got %0d want 255", p1_pos); end
    count_lines(1'b0, n);
    checks++; if (n !== 255) begin errors++; $display("FAIL ana_max_lines: got %0d want 255", n); end
    mode = 2'd2; analog1 = 16'h0000;
    frame();
    checks++; if (p1_pos !== 8'd128) begin errors++; $display("FAIL ana_x_p1: got %0d want 128", p1_pos); end
    checks++; if (p2_pos !== 8'd128) begin errors++; $display("FAIL ana_x_p2: got %0d want 128", p2_pos); end
    count_lines(1'b1, n);
    checks++; if (n !== 128) begin errors++; $display("FAIL ana_x_lines: got %0d want 128", n); end
  endtask

  task automatic test_mode_switch();
    // Back to digital: position continues from the last analog value.
    mode = 2'd0; p1_down = 1'b1; p1_up = 1'b1;
    analog0 = 16'h8000;
    frame();
    checks++; if (p1_pos !== 8'd128) begin errors++; $display("FAIL mode_keep: got %0d want 128", p1_pos); end
    p1_up = 1'b0;
    frame();
    checks++; if (p1_pos !== 8'd133) begin errors++; $display("FAIL mode_digital_step: got %0d want 133", p1_pos); end
    p1_down = 1'b0;
  endtask

  task automatic test_reset_mid();
    mode = 2'd1; analog0 = 16'hBC00;
    frame();
    for (int i = 0; i < 10; i++) line();
    checks++; if (p1_pos !== 8'd60) begin errors++; $display("FAIL mid_pos: got %0d want 60", p1_pos); end
    checks++; if (lp_in !== 1'b0) begin errors++; $display("FAIL mid_lp: got %0b want 0", lp_in); end
    reset = 1'b1; tick();
    reset = 1'b0;
    checks++; if (lp_in !== 1'b1) begin errors++; $display("FAIL mid_reset_lp: got %0b want 1", lp_in); end
    checks++; if (p1_pos !== 8'd128) begin errors++; $display("FAIL mid_reset_pos: got %0d want 128", p1_pos); end
    checks++; if (rp_in !== 1'b1) begin errors++; $display("FAIL mid_reset_rp: got %0b want 1", rp_in); end
    mode = 2'd0;
    tick();
  endtask

  task automatic test_vs_held();
    int n;
    // Long vs pulse with lines during it: one frame action, later lines still count.
    p1_down = 1'b1;
    vs = 1'b1; tick();
    for (int i = 0; i < 3; i++) line();
    vs = 1'b0; tick();
    p1_down = 1'b0;
    checks++; if (p1_pos !== 8'd133) begin errors++; $display("FAIL vs_held_pos: got %0d want 133", p1_pos); end
    count_lines(1'b0, n);
    checks++; if (n !== 125) begin errors++; $display("FAIL vs_held_lines: got %0d want 125", n); end
  endtask

  initial begin
    test_reset();
    test_digital_down();
    test_both_held();
    test_saturate();
    test_analog();
    test_mode_switch();
    test_reset_mid();
    test_vs_held();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
